// File: rtl/issue_queue.sv
// In-order issue queue feeding the adder and multiplier reservation stations.
// Optional `ISSUE_STATS_EN adds a saturating StallCount output.
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int IW    = 16
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic [IW-1:0]            InstrIn,
    input  logic                     InstrValid,
    output logic                     QueueFull,
    output logic                     QueueEmpty,
    output logic [$clog2(DEPTH):0]   Count,
    input  logic [7:0]               AdderBusy,
    input  logic [7:0]               MultBusy,
    output logic [IW-1:0]            instruction,
    output logic                     Adderin,
    output logic                     Multin,
    output logic                     IllegalOp
`ifdef ISSUE_STATS_EN
    ,
    output logic [15:0]              StallCount
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_MUL,
        CLS_DROP,
        CLS_ILLEGAL
    } op_class_e;

    logic [IW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          add_stb_q, add_stb_d;
    logic          mul_stb_q, mul_stb_d;
    logic          illegal_q, illegal_d;
    logic          add_blk_q, add_blk_d;
    logic          mul_blk_q, mul_blk_d;

    logic [IW-1:0] head;
    op_class_e     head_cls;
    logic          empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign push  = InstrValid && !full;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        unique case (head[IW-1 -: 4])
            4'h0, 4'h1: head_cls = CLS_ADD;
            4'h2, 4'h3: head_cls = CLS_MUL;
            4'hF:       head_cls = CLS_DROP;
            default:    head_cls = CLS_ILLEGAL;
        endcase
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        pop       = 1'b0;
        add_stb_d = 1'b0;
        mul_stb_d = 1'b0;
        illegal_d = illegal_q;
        instr_d   = instr_q;
        if (!empty) begin
            unique case (head_cls)
                CLS_ADD: if (AdderBusy != 8'hFF && !add_blk_q) begin
                    pop       = 1'b1;
                    add_stb_d = 1'b1;
                    instr_d   = head;
                end
                CLS_MUL: if (MultBusy != 8'hFF && !mul_blk_q) begin
                    pop       = 1'b1;
                    mul_stb_d = 1'b1;
                    instr_d   = head;
                end
                CLS_DROP: pop = 1'b1;
                CLS_ILLEGAL: begin
                    pop       = 1'b1;
                    illegal_d = 1'b1;
                end
            endcase
        end
        // Blackout lasts exactly one edge: the station's Busy lags its strobe by one cycle.
        add_blk_d = add_stb_d;
        mul_blk_d = mul_stb_d;
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: the storage array carries no reset; pointers and count alone define validity.
    always_ff @(posedge Clock) begin
        if (push) mem_q[wr_ptr_q] <= InstrIn;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            instr_q   <= '0;
            add_stb_q <= 1'b0;
            mul_stb_q <= 1'b0;
            illegal_q <= 1'b0;
            add_blk_q <= 1'b0;
            mul_blk_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            instr_q   <= instr_d;
            add_stb_q <= add_stb_d;
            mul_stb_q <= mul_stb_d;
            illegal_q <= illegal_d;
            add_blk_q <= add_blk_d;
            mul_blk_q <= mul_blk_d;
        end
    end

`ifdef ISSUE_STATS_EN
    logic [15:0] stall_q, stall_d;

    // A non-empty queue that does not pop is a held head.
    always_comb begin
        stall_d = stall_q;
        if (!empty && !pop && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    assign StallCount = stall_q;
`endif

    assign QueueFull   = full;
    assign QueueEmpty  = empty;
    assign Count       = count_q;
    assign instruction = instr_q;
    assign Adderin     = add_stb_q;
    assign Multin      = mul_stb_q;
    assign IllegalOp   = illegal_q;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: issue, blackout, blocking, full/wrap, drops, reset.
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int IW    = 16;

    logic                  Clock = 1'b0;
    logic                  Resetn;
    logic [IW-1:0]         InstrIn;
    logic                  InstrValid;
    logic                  QueueFull, QueueEmpty;
    logic [$clog2(DEPTH):0] Count;
    logic [7:0]            AdderBusy, MultBusy;
    logic [IW-1:0]         instruction;
    logic                  Adderin, Multin, IllegalOp;
`ifdef ISSUE_STATS_EN
    logic [15:0]           StallCount;
`endif

    int checks = 0;
    int errors = 0;

    issue_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .InstrIn     (InstrIn),
        .InstrValid  (InstrValid),
        .QueueFull   (QueueFull),
        .QueueEmpty  (QueueEmpty),
        .Count       (Count),
        .AdderBusy   (AdderBusy),
        .MultBusy    (MultBusy),
        .instruction (instruction),
        .Adderin     (Adderin),
        .Multin      (Multin),
        .IllegalOp   (IllegalOp)
`ifdef ISSUE_STATS_EN
        ,
        .StallCount  (StallCount)
`endif
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_drain(input logic [15:0] base);
        int n;
        AdderBusy = 8'hFF;
        for (int i = 0; i < DEPTH; i++) begin
            InstrValid = 1'b1;
            InstrIn    = base + 16'(i);
            tick();
            check("fill_no_strobe", 32'(Adderin), 32'd0);
        end
        check("full_count", 32'(Count), 32'd8);
        check("full_flag", 32'(QueueFull), 32'd1);
        InstrIn = 16'h0FFF;
        tick();
        InstrValid = 1'b0;
        check("push_when_full_count", 32'(Count), 32'd8);
        AdderBusy = 8'h00;
        n = 0;
        for (int c = 0; c < 24 && n < DEPTH; c++) begin
            tick();
            if (Adderin) begin
                check("drain_order", 32'(instruction), 32'(base + 16'(n)));
                n++;
            end
        end
        check("drain_issue_count", 32'(n), 32'd8);
        check("drain_empty", 32'(QueueEmpty), 32'd1);
        tick();
        check("drain_no_ninth", 32'(Adderin), 32'd0);
        check("drain_count", 32'(Count), 32'd0);
    endtask

    initial begin
        Resetn = 1'b0; InstrValid = 1'b0; InstrIn = '0;
        AdderBusy = 8'h00; MultBusy = 8'h00;
        tick(); tick();
        check("rst_count", 32'(Count), 32'd0);
        check("rst_empty", 32'(QueueEmpty), 32'd1);
        check("rst_full", 32'(QueueFull), 32'd0);
        check("rst_adderin", 32'(Adderin), 32'd0);
        check("rst_multin", 32'(Multin), 32'd0);
        check("rst_illegal", 32'(IllegalOp), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
        Resetn = 1'b1;

        // Basic issue: push at E0, strobe during E1..E2.
        InstrValid = 1'b1; InstrIn = 16'h0123;
        tick();
        InstrValid = 1'b0;
        check("basic_count_after_push", 32'(Count), 32'd1);
        check("basic_no_early_strobe", 32'(Adderin), 32'd0);
        tick();
        check("basic_adderin", 32'(Adderin), 32'd1);
        check("basic_instr", 32'(instruction), 32'h0123);
        check("basic_multin", 32'(Multin), 32'd0);
        check("basic_empty", 32'(QueueEmpty), 32'd1);
        tick();
        check("basic_strobe_one_cycle", 32'(Adderin), 32'd0);
        check("basic_instr_hold", 32'(instruction), 32'h0123);

        // Back-to-back ADDs: strobe pattern 1,0,1,0,1 with in-order instructions.
        for (int i = 0; i < 6; i++) begin
            InstrValid = (i < 3);
            InstrIn    = 16'(i + 1);
            tick();
            if (i > 0) begin
                check("b2b_adderin", 32'(Adderin), 32'(i % 2));
                check("b2b_instr", 32'(instruction), 32'((i + 1) / 2));
            end
        end
        tick();
        check("b2b_final_idle", 32'(Adderin), 32'd0);
        check("b2b_final_empty", 32'(QueueEmpty), 32'd1);

        // Head-of-line blocking.
        AdderBusy = 8'hFF;
        InstrValid = 1'b1; InstrIn = 16'h0AAA;
        tick();
        InstrIn = 16'h2BBB;
        tick();
        InstrValid = 1'b0;
        tick();
        check("hol_count", 32'(Count), 32'd2);
        check("hol_no_add", 32'(Adderin), 32'd0);
        check("hol_no_mul", 32'(Multin), 32'd0);
`ifdef ISSUE_STATS_EN
        check("hol_stalls", 32'(StallCount), 32'd4);
`endif
        AdderBusy = 8'h7F;
        tick();
        check("hol_add_issue", 32'(Adderin), 32'd1);
        check("hol_add_instr", 32'(instruction), 32'h0AAA);
        check("hol_add_not_mul", 32'(Multin), 32'd0);
        tick();
        check("hol_mul_issue", 32'(Multin), 32'd1);
        check("hol_mul_not_add", 32'(Adderin), 32'd0);
        check("hol_mul_instr", 32'(instruction), 32'h2BBB);
        check("hol_empty", 32'(Count), 32'd0);
        tick();
        check("hol_mul_one_cycle", 32'(Multin), 32'd0);

        // Full queue, then a second fill to exercise pointer wrap.
        fill_drain(16'h0100);
        fill_drain(16'h1200);

        // Drop paths: NOP then illegal opcode 0x7.
        InstrValid = 1'b1; InstrIn = 16'hF000;
        tick();
        InstrIn = 16'h7000;
        tick();
        InstrValid = 1'b0;
        check("nop_no_add", 32'(Adderin), 32'd0);
        check("nop_no_mul", 32'(Multin), 32'd0);
        check("nop_not_illegal", 32'(IllegalOp), 32'd0);
        check("nop_popped_count", 32'(Count), 32'd1);
        tick();
        check("ill_flag", 32'(IllegalOp), 32'd1);
        check("ill_no_add", 32'(Adderin), 32'd0);
        check("ill_no_mul", 32'(Multin), 32'd0);
        check("ill_empty", 32'(QueueEmpty), 32'd1);
        tick(); tick();
        check("ill_sticky", 32'(IllegalOp), 32'd1);

        // Reset mid-operation with 4 entries queued and Adderin high.
        AdderBusy = 8'hFF;
        InstrValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            InstrIn = 16'h0301 + 16'(i);
            tick();
        end
        InstrValid = 1'b0;
        AdderBusy = 8'h00;
        tick();
        check("mid_adderin", 32'(Adderin), 32'd1);
        check("mid_count", 32'(Count), 32'd4);
        Resetn = 1'b0;
        tick();
        check("mid_rst_count", 32'(Count), 32'd0);
        check("mid_rst_adderin", 32'(Adderin), 32'd0);
        check("mid_rst_multin", 32'(Multin), 32'd0);
        check("mid_rst_empty", 32'(QueueEmpty), 32'd1);
        check("mid_rst_illegal", 32'(IllegalOp), 32'd0);
        check("mid_rst_instr", 32'(instruction), 32'd0);
`ifdef ISSUE_STATS_EN
        check("mid_rst_stalls", 32'(StallCount), 32'd0);
`endif
        Resetn = 1'b1;
        tick();
        check("post_rst_no_strobe", 32'(Adderin), 32'd0);
        check("post_rst_count", 32'(Count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

In-order instruction issue queue that sits directly upstream of the adder and multiplier reservation stations. It buffers decoded 16-bit instructions from fetch and dispatches the head instruction to the matching station when that station reports a free entry. It drives the station's `instruction` bus and a one-cycle load strobe (`Adderin` / `Multin`). The block is single-clock and strictly in-order: a blocked head stalls the whole queue.

## Interface
Parameters:
- `DEPTH`, 8, number of queue entries; must be a power of two, at least 2.
- `IW`, 16, instruction width; the opcode is bits `[IW-1:IW-4]`.

Ports:
- `Clock`  in  1  single clock; all state changes on the rising edge.
- `Resetn`  in  1  reset, synchronous, active-low.
- `InstrIn`  in  IW  instruction from fetch.
- `InstrValid`  in  1  push request; sampled at the rising edge.
- `QueueFull`  out  1  high when count == `DEPTH`.
- `QueueEmpty`  out  1  high when count == 0.
- `Count`  out  $clog2(DEPTH)+1  current occupancy.
- `AdderBusy`  in  8  Busy vector from the adder reservation station.
- `MultBusy`  in  8  Busy vector from the multiplier reservation station.
- `instruction`  out  IW  registered instruction presented to both stations.
- `Adderin`  out  1  registered one-cycle load strobe to the adder station.
- `Multin`  out  1  registered one-cycle load strobe to the multiplier station.
- `IllegalOp`  out  1  sticky flag; set when an undefined opcode is dropped.

## Operation
- **Reset:** when `Resetn`=0 at an edge, all of the following are cleared: read/write pointers, `Count`, `instruction`, `Adderin`, `Multin`, `IllegalOp`, both blackout flags, and the stats counter. After reset, `QueueEmpty`=1 and `QueueFull`=0. Reset asserted mid-operation discards all queued entries; no strobe fires in the cycle after reset.
- **Push:**
  - Accepted when `InstrValid`=1 and `QueueFull`=0.
  - When full, the push is ignored even if a pop occurs in the same cycle; fetch must hold the instruction.
  - Pointers wrap modulo `DEPTH`.
- **Opcode class:**
  - 0x0 ADD, 0x1 SUB: adder class.
  - 0x2 MUL, 0x3 DIV: multiplier class.
  - 0xF NOP: drop class.
  - Any other value: illegal class.
- **Issue decision** at each edge, when the queue is non-empty and no reset is active:
  - **Adder class:** issue when `AdderBusy` != 8'hFF and `AddBlk`=0. On issue: pop the entry, load `instruction`, set `Adderin`=1, set `AddBlk`=1.
  - **Multiplier class:** same rule, using `MultBusy`, `Multin` and `MulBlk`.
  - **NOP:** pop with no strobe.
  - **Illegal:** pop with no strobe and set `IllegalOp`.
  - **Otherwise:** hold; the head stays and both strobes are 0.
- **Blackout:** each blackout flag (`AddBlk`, `MulBlk`) clears on the edge after it was set. The station updates its Busy vector one edge after sampling its strobe, so this one-cycle gap prevents a double issue into a single remaining free entry. The effect is a maximum issue rate of one per 2 cycles per class. An adder issue and a multiplier issue may alternate on consecutive cycles.
- **Strobes:** at most one strobe is high per cycle. Each strobe is high for exactly one cycle per issue. `instruction` holds its last value when no issue occurs.
- **Count:** on a simultaneous push and pop (queue not full), `Count` is unchanged and both pointers advance.

## Timing
- **Latency:**
  - Push sampled at edge E0 into an empty queue: the issue decision is made at E1, `Adderin`/`Multin` are high during E1→E2, and the station samples at E2.
  - Minimum latency from push edge to strobe is 1 cycle.
- **Flag timing:** `QueueFull`, `QueueEmpty` and `Count` reflect the registered state and update one edge after a push or pop.
- **Busy sampling:** the Busy inputs are sampled at the decision edge only; no combinational path exists from a Busy input to any output.

## Configuration
- **`ISSUE_STATS_EN` defined:** adds the output `StallCount` (16 bits). It increments at every edge where the queue is non-empty and the head is held, i.e. its station is full or blackout is active. It saturates at 16'hFFFF and is cleared by reset.
- **`ISSUE_STATS_EN` undefined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Basic issue:** after reset, push ADD 16'h0123 with `AdderBusy`=0 → `Adderin`=1 for one cycle, with `instruction`=16'h0123 on the cycle after the push edge. `QueueEmpty` returns to 1.
- **Back-to-back ADDs:** push 3 ADDs on consecutive cycles with `AdderBusy`=0 → `Adderin` pulses on alternating cycles (1,0,1,0,1), in order.
- **Head-of-line blocking:** with `AdderBusy`=8'hFF, push ADD then MUL → no strobes and `Count`=2. Then drop `AdderBusy` to 8'h7F → `Adderin` pulses, followed on the next cycle by `Multin`.
- **Full queue:** fill `DEPTH`=8 with `AdderBusy`=8'hFF → `QueueFull`=1, and a 9th push is ignored. Release Busy → exactly 8 issues, with pointer wrap verified by a second fill.
- **Drop paths:** push NOP 16'hF000 and opcode 0x7 → both are popped, no strobe fires, `IllegalOp`=1 and stays set until reset.
- **Reset mid-operation:** assert `Resetn`=0 with 4 entries queued and `Adderin` high → next cycle `Count`=0 and both strobes are 0. With `ISSUE_STATS_EN`, `StallCount`=0 after reset.
